// File: rtl/fir_out_requant.sv
// Output requantiser: decimate, round, shift, saturate, then buffer in a small
// FIFO with a valid/ready output. Sticky flags report saturation and drops.
module fir_out_requant #(
    parameter int unsigned DIN_W      = 54,
    parameter int unsigned DOUT_W     = 18,
    parameter int unsigned SHIFT      = 16,
    parameter int unsigned DECIM      = 4,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          clr,
    input  logic [DIN_W-1:0]              din,
    input  logic                          din_vld,
    output logic [DOUT_W-1:0]             dout,
    output logic                          dout_vld,
    input  logic                          dout_rdy,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic                          sat,
    output logic                          ovf
);

    localparam int unsigned PH_W = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam int unsigned AW   = $clog2(FIFO_DEPTH);
    localparam int unsigned EW   = DIN_W + 1;

    // Half an output LSB; shifting a one left then right yields zero for SHIFT=0.
    localparam logic [EW-1:0] RND = ({{(EW-1){1'b0}}, 1'b1} << SHIFT) >> 1;
    localparam logic signed [EW-1:0] MAX_E = {{(EW-DOUT_W+1){1'b0}}, {(DOUT_W-1){1'b1}}};
    localparam logic signed [EW-1:0] MIN_E = {{(EW-DOUT_W+1){1'b1}}, {(DOUT_W-1){1'b0}}};
    localparam logic [DOUT_W-1:0] MAX_O = {1'b0, {(DOUT_W-1){1'b1}}};
    localparam logic [DOUT_W-1:0] MIN_O = {1'b1, {(DOUT_W-1){1'b0}}};

    logic [PH_W-1:0]         ph_q, ph_d;
    logic signed [EW-1:0]    s1_q, s1_d, rnd_sum;
    logic                    s1_vld_q, s1_vld_d;
    logic [DOUT_W-1:0]       s2_q, s2_d;
    logic                    s2_vld_q, s2_vld_d;
    logic                    sat_q, sat_d, ovf_q, ovf_d;
    logic [AW-1:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]             cnt_q, cnt_d;
    logic [DOUT_W-1:0]       mem_q [FIFO_DEPTH];

    logic keep, sat_hi, sat_lo, fifo_empty, fifo_full, fifo_rd, fifo_wr, fifo_drop;

    // Decimation, rounding/saturation pipeline and FIFO control next-state.
    always_comb begin
        keep       = din_vld && (ph_q == '0);
        rnd_sum    = $signed({din[DIN_W-1], din}) + $signed(RND);
        sat_hi     = s1_q > MAX_E;
        sat_lo     = s1_q < MIN_E;
        fifo_empty = (cnt_q == '0);
        fifo_full  = (cnt_q == (AW+1)'(FIFO_DEPTH));
        fifo_rd    = !clr && !fifo_empty && dout_rdy;
        // A full FIFO still accepts the write when the head leaves in the same cycle.
        fifo_wr    = !clr && s2_vld_q && (!fifo_full || fifo_rd);
        fifo_drop  = !clr && s2_vld_q && fifo_full && !fifo_rd;

        ph_d     = ph_q;
        s1_d     = s1_q;
        s1_vld_d = !clr && keep;
        s2_d     = s2_q;
        s2_vld_d = !clr && s1_vld_q;
        sat_d    = sat_q;
        ovf_d    = ovf_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;

        if (din_vld) begin
            ph_d = (ph_q == PH_W'(DECIM - 1)) ? '0 : ph_q + 1'b1;
        end
        if (keep) begin
            s1_d = rnd_sum >>> SHIFT;
        end
        if (s1_vld_q) begin
            if (sat_hi) begin
                s2_d = MAX_O;
            end else if (sat_lo) begin
                s2_d = MIN_O;
            end else begin
                s2_d = s1_q[DOUT_W-1:0];
            end
            sat_d = sat_q | sat_hi | sat_lo;
        end
        if (fifo_drop) begin
            ovf_d = 1'b1;
        end
        if (fifo_wr) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (fifo_rd) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        unique case ({fifo_wr, fifo_rd})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase

        // Clear wins over everything decided above.
        if (clr) begin
            ph_d     = '0;
            sat_d    = 1'b0;
            ovf_d    = 1'b0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end
    end

    // Control and pipeline state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ph_q     <= '0;
            s1_q     <= '0;
            s1_vld_q <= 1'b0;
            s2_q     <= '0;
            s2_vld_q <= 1'b0;
            sat_q    <= 1'b0;
            ovf_q    <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            ph_q     <= ph_d;
            s1_q     <= s1_d;
            s1_vld_q <= s1_vld_d;
            s2_q     <= s2_d;
            s2_vld_q <= s2_vld_d;
            sat_q    <= sat_d;
            ovf_q    <= ovf_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // FIFO storage; contents are don't-care while the occupancy says empty.
    always_ff @(posedge clk) begin
        if (fifo_wr) begin
            mem_q[wr_ptr_q] <= s2_q;
        end
    end

    // Outputs derived purely from registered FIFO state.
    always_comb begin
        dout     = '0;
        dout_vld = !fifo_empty;
        level    = cnt_q;
        sat      = sat_q;
        ovf      = ovf_q;
        if (!fifo_empty) begin
            dout = mem_q[rd_ptr_q];
        end
    end

endmodule

// File: tb/tb_fir_out_requant.sv
// Bench for fir_out_requant: two instances (DECIM=1 and DECIM=4) share stimulus
// and are compared every cycle against a queue-based reference model.
module tb_fir_out_requant;

    logic        clk = 1'b0;
    logic        rst, clr, din_vld, dout_rdy;
    logic [53:0] din;
    logic [17:0] dout0, dout1;
    logic        vld0, vld1, sat0, sat1, ovf0, ovf1;
    logic [2:0]  lvl0, lvl1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fir_out_requant #(.DECIM(1)) u_d1 (
        .clk(clk), .rst(rst), .clr(clr), .din(din), .din_vld(din_vld),
        .dout(dout0), .dout_vld(vld0), .dout_rdy(dout_rdy), .level(lvl0),
        .sat(sat0), .ovf(ovf0)
    );

    fir_out_requant #(.DECIM(4)) u_d4 (
        .clk(clk), .rst(rst), .clr(clr), .din(din), .din_vld(din_vld),
        .dout(dout1), .dout_vld(vld1), .dout_rdy(dout_rdy), .level(lvl1),
        .sat(sat1), .ovf(ovf1)
    );

    // Reference model: kept samples travel as (value, due edge) records.
    typedef struct {
        int     inst;
        longint val;
        bit     sat;
        int     due;
    } pend_t;

    pend_t  pq[$];
    longint fq[2][4];
    int     cnt[2];
    bit     e_sat[2], e_ovf[2];
    int     ph[2];
    int     edge_n = 0;

    function automatic int decim(int k);
        return (k == 0) ? 1 : 4;
    endfunction

    // Round half toward +inf after dividing by 2^16.
    function automatic longint rnd16(longint x);
        return (x + 64'sd32768) >>> 16;
    endfunction

    task automatic check(string tag, longint got, longint exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_step();
        bit     rd[2];
        pend_t  p;
        longint x, r;
        edge_n++;
        if (rst || clr) begin
            for (int k = 0; k < 2; k++) begin
                cnt[k] = 0; e_sat[k] = 0; e_ovf[k] = 0; ph[k] = 0;
            end
            pq.delete();
            return;
        end
        for (int k = 0; k < 2; k++) rd[k] = (cnt[k] > 0) && dout_rdy;
        foreach (pq[i]) if (pq[i].due == edge_n + 1 && pq[i].sat) e_sat[pq[i].inst] = 1;
        for (int k = 0; k < 2; k++) begin
            if (rd[k]) begin
                for (int j = 0; j < 3; j++) fq[k][j] = fq[k][j+1];
                cnt[k]--;
            end
        end
        while (pq.size() > 0 && pq[0].due == edge_n) begin
            p = pq.pop_front();
            if (cnt[p.inst] < 4) begin
                fq[p.inst][cnt[p.inst]] = p.val;
                cnt[p.inst]++;
            end else begin
                e_ovf[p.inst] = 1;
            end
        end
        if (din_vld) begin
            x = longint'($signed(din));
            r = rnd16(x);
            for (int k = 0; k < 2; k++) begin
                if (ph[k] == 0) begin
                    p.inst = k;
                    p.sat  = (r > 131071) || (r < -131072);
                    p.val  = (r > 131071) ? 131071 : (r < -131072) ? -131072 : r;
                    p.due  = edge_n + 2;
                    pq.push_back(p);
                end
                ph[k] = (ph[k] + 1) % decim(k);
            end
        end
    endtask

    task automatic check_all();
        check("dout_d1", longint'($signed(dout0)), (cnt[0] > 0) ? fq[0][0] : 0);
        check("vld_d1", vld0, cnt[0] > 0);
        check("level_d1", lvl0, cnt[0]);
        check("sat_d1", sat0, e_sat[0]);
        check("ovf_d1", ovf0, e_ovf[0]);
        check("dout_d4", longint'($signed(dout1)), (cnt[1] > 0) ? fq[1][0] : 0);
        check("vld_d4", vld1, cnt[1] > 0);
        check("level_d4", lvl1, cnt[1]);
        check("sat_d4", sat1, e_sat[1]);
        check("ovf_d4", ovf1, e_ovf[1]);
    endtask

    // One clock: model the edge, let it happen, sample on the falling edge.
    task automatic cyc();
        model_step();
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    task automatic drive(longint x, bit v);
        din     = x[53:0];
        din_vld = v;
    endtask

    task automatic idle(int n);
        drive(0, 0);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic pulse_clr();
        drive(0, 0);
        clr = 1'b1;
        cyc();
        clr = 1'b0;
    endtask

    function automatic longint rand_din();
        longint x;
        x = {$urandom, $urandom};
        case ($urandom_range(0, 3))
            0:       x = x >>> 40;
            1:       x = x >>> 26;
            2:       x = x >>> 10;
            default: x = (longint'(131071) <<< 16) + 32768 - longint'($urandom_range(0, 1));
        endcase
        if ($urandom_range(0, 3) == 0 && x > 0) x = -x;
        return x;
    endfunction

    initial begin
        longint rnd_exp[4];
        longint sat_exp[3];
        rst = 1'b1; clr = 1'b0; dout_rdy = 1'b0;
        drive(0, 0);
        idle(2);
        rst = 1'b0;
        idle(1);

        // Scale and latency.
        dout_rdy = 1'b1;
        drive(65536000, 1); cyc();
        drive(0, 0); cyc();
        check("lat_e1_vld", vld0, 0);
        cyc();
        check("lat_e2_vld", vld0, 1);
        check("lat_dout", longint'($signed(dout0)), 1000);
        cyc();
        check("lat_drain_vld", vld0, 0);
        check("lat_drain_lvl", lvl0, 0);

        // Rounding.
        dout_rdy = 1'b0;
        rnd_exp = '{1, 0, 0, -1};
        drive(32768, 1); cyc();
        drive(32767, 1); cyc();
        drive(-32768, 1); cyc();
        drive(-32769, 1); cyc();
        idle(3);
        dout_rdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("rnd_val", longint'($signed(dout0)), rnd_exp[i]);
            cyc();
        end
        check("rnd_sat", sat0, 0);

        // Saturation and sticky flag.
        pulse_clr();
        dout_rdy = 1'b0;
        sat_exp = '{131071, -131072, 1};
        drive(longint'(1) <<< 40, 1); cyc();
        drive(-(longint'(1) <<< 40), 1); cyc();
        drive(65536, 1); cyc();
        idle(3);
        check("sat_set", sat0, 1);
        dout_rdy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("sat_val", longint'($signed(dout0)), sat_exp[i]);
            cyc();
        end
        check("sat_sticky", sat0, 1);
        pulse_clr();
        check("sat_cleared", sat0, 0);

        // Decimation by 4 on the second instance.
        dout_rdy = 1'b0;
        for (int k = 0; k < 8; k++) begin
            drive(longint'(k) * 65536, 1);
            cyc();
        end
        idle(3);
        check("dec_level", lvl1, 2);
        dout_rdy = 1'b1;
        check("dec_first", longint'($signed(dout1)), 0);
        cyc();
        check("dec_second", longint'($signed(dout1)), 4);
        cyc();
        check("dec_empty", vld1, 0);

        // Overflow on the DECIM=1 instance.
        pulse_clr();
        dout_rdy = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            drive(longint'(k) * 65536, 1);
            cyc();
        end
        idle(3);
        check("ovf_level", lvl0, 4);
        check("ovf_flag", ovf0, 1);
        dout_rdy = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            check("ovf_drain", longint'($signed(dout0)), k);
            cyc();
        end
        check("ovf_empty_vld", vld0, 0);
        check("ovf_empty_dout", longint'($signed(dout0)), 0);

        // Asynchronous reset mid-stream.
        pulse_clr();
        dout_rdy = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            drive(longint'(k) * 65536, 1);
            cyc();
        end
        check("pre_rst_level", lvl0, 3);
        drive(0, 0);
        rst = 1'b1;
        #1;
        check("rst_vld", vld0, 0);
        check("rst_level", lvl0, 0);
        check("rst_sat", sat0, 0);
        check("rst_ovf", ovf0, 0);
        cyc();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cyc();
            check("rst_quiet", vld0, 0);
        end
        drive(7 * 65536, 1); cyc();
        drive(0, 0); cyc();
        check("rst_lat_e1", vld0, 0);
        cyc();
        check("rst_lat_vld", vld0, 1);
        check("rst_lat_dout", longint'($signed(dout0)), 7);

        // Randomised traffic with occasional clears.
        pulse_clr();
        for (int i = 0; i < 800; i++) begin
            drive(rand_din(), $urandom_range(0, 2) != 0);
            dout_rdy = $urandom_range(0, 3) != 0;
            clr      = $urandom_range(0, 99) == 0;
            cyc();
        end
        clr = 1'b0;
        dout_rdy = 1'b1;
        idle(8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fir_out_requant.md
# fir_out_requant

Output requantiser for the FIR filter datapath. It consumes the filter's full-precision 54-bit signed accumulator output and decimates it by a fixed ratio. Each kept sample is rounded, right-shifted and saturated to an 18-bit signed word, then buffered in a small FIFO with a valid/ready output handshake. Sticky flags report saturation and FIFO overflow.

## Interface
- DIN_W, 54, input sample width (signed, two's complement)
- DOUT_W, 18, output sample width (signed)
- SHIFT, 16, arithmetic right shift applied after rounding; legal range 0..DIN_W-DOUT_W
- DECIM, 4, decimation ratio; 1 keeps every sample
- FIFO_DEPTH, 4, output FIFO entries; power of two, ≥2

- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- clr  in  1  synchronous clear: flags, decimation counter, pipeline and FIFO
- din  in  DIN_W  filter accumulator output
- din_vld  in  1  din valid this cycle; there is no backpressure to the filter
- dout  out  DOUT_W  FIFO head sample; 0 while FIFO empty
- dout_vld  out  1  FIFO not empty
- dout_rdy  in  1  consumer accepts head when dout_vld && dout_rdy
- level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
- sat  out  1  sticky: at least one kept sample saturated
- ovf  out  1  sticky: at least one sample dropped on full FIFO

## Operation
- Decimation counter ph: 0..DECIM-1.
  - Increments on each din_vld and wraps to 0.
  - A sample is kept only when din_vld && ph==0, so the first din_vld after reset/clr is kept.
- Stage 1 (round), registered:
  - Sign-extend din to DIN_W+1 bits.
  - Add 2^(SHIFT-1); with SHIFT=0, add nothing.
  - Arithmetic shift right by SHIFT.
  - Result: round-half-toward-+inf.
- Stage 2 (saturate), registered:
  - Result > 2^(DOUT_W-1)-1 → 2^(DOUT_W-1)-1.
  - Result < -2^(DOUT_W-1) → -2^(DOUT_W-1).
  - Either case sets sat.
- Stage 3: FIFO write of the stage-2 word.
  - If the FIFO is full and no read occurs that cycle, the word is dropped and ovf is set.
  - Full with simultaneous read: the write succeeds and level is unchanged.
- FIFO read on dout_vld && dout_rdy.
  - dout_rdy while empty is ignored.
  - Simultaneous read+write when not full and not empty: level unchanged.
- Pointers wrap modulo FIFO_DEPTH.
- sat and ovf clear only on rst or clr.
- clr has priority over all same-cycle activity.
  - Sets ph=0, invalidates both pipeline stages, empties the FIFO, clears the flags.
  - A din_vld in the clr cycle is discarded.

## Timing
- Reset (async assert, state held until deassert): dout=0, dout_vld=0, level=0, sat=0, ovf=0, ph=0, pipeline valids=0.
- Latency, empty FIFO: din_vld sampled at edge E0 → stage 1 valid after E0 → stage 2 valid after E1 → FIFO write at E2.
  - dout_vld=1 and dout valid in the cycle after E2, i.e. 3 edges after acceptance.
- Throughput: one kept sample per cycle sustained (DECIM=1, dout_rdy=1); no bubbles.
- dout_vld, dout and level are derived from FIFO state and change only on clock edges.
- Flags assert on the edge that performs the saturating stage-2 load or the dropped write.
- Reset asserted mid-stream: all in-flight and buffered samples are lost; no spurious dout_vld after release.

## Test plan
- Scale/latency (SHIFT=16, DECIM=1):
  - din=65536000 with one-cycle din_vld → dout=1000, dout_vld high exactly 3 edges later.
  - With dout_rdy=1, dout_vld is high for one cycle; level returns to 0.
- Rounding (SHIFT=16):
  - din=32768 → 1; din=32767 → 0.
  - din=-32768 → 0; din=-32769 → -1.
  - sat stays 0 throughout.
- Saturation:
  - din=2^40 → 131071 with sat=1.
  - din=-2^40 → -131072.
  - Following din=65536 → 1; sat stays 1 until clr pulse, then 0.
- Decimation (DECIM=4): din = k·65536 for k=0..7 on consecutive din_vld → outputs 0, 4 only, in order.
- Overflow (DECIM=1, dout_rdy=0): 6 consecutive samples 1..6 (×65536).
  - level=4, ovf=1.
  - Draining yields 1, 2, 3, 4, then dout_vld=0 and dout=0.
- Reset/clear mid-stream:
  - rst pulse with 3 samples buffered and 2 in pipeline → dout_vld=0, level=0, flags 0.
  - No output for 5 cycles after release.
  - Next sample appears with 3-edge latency.
